mem_io_responder: RTL and testbench

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

---
 rtl/mem_io_pkg.sv | 57 +++++
 rtl/mem_io_responder_kbd_fifo.sv | 86 ++++++++
 rtl/mem_io_responder.sv | 144 ++++++++++++++
 tb/tb_mem_io_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_pkg.sv
// Shared constants and address decode for the memory-mapped I/O responder.
// Holds the RAM/peripheral address map, the bit positions used in the
// keyboard data/status words, and the region decode helper.
package mem_io_pkg;

    // Base of the data RAM window and the fixed peripheral register addresses
    localparam logic [31:0] RAM_BASE        = 32'h1001_0000;
    localparam logic [31:0] IO_BASE         = 32'h1002_0000;
    localparam logic [31:0] KBD_DATA_OFF    = 32'h0000_0000;
    localparam logic [31:0] KBD_STATUS_OFF  = 32'h0000_0004;
    localparam logic [31:0] LED_OFF         = 32'h0000_0008;
    localparam logic [31:0] CYCLE_OFF       = 32'h0000_000C;

    localparam logic [31:0] KBD_DATA_ADDR   = IO_BASE + KBD_DATA_OFF;
    localparam logic [31:0] KBD_STATUS_ADDR = IO_BASE + KBD_STATUS_OFF;
    localparam logic [31:0] LED_ADDR        = IO_BASE + LED_OFF;
    localparam logic [31:0] CYCLE_ADDR      = IO_BASE + CYCLE_OFF;

    // Keyboard word layout: valid flag above the scan code, overflow flag
    // above the low count nibble in the status word
    localparam int KBD_DATA_VALID_BIT  = 8;
    localparam int KBD_STATUS_OVF_BIT  = 8;
    localparam int KBD_STATUS_CNT_LSB  = 0;
    localparam int KBD_STATUS_CNT_W    = 4;
    localparam int KBD_CODE_W          = 8;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_RAM,
        REG_KBD_DATA,
        REG_KBD_STATUS,
        REG_LED,
        REG_CYCLE
    } region_e;

    // Word-addressed decode: the two byte-offset bits never affect the target
    function automatic region_e decodeRegion(input logic [31:0] addr,
                                             input logic [31:0] ramBytes);
        logic [31:0] wordAddr;
        region_e     region;
        wordAddr = {addr[31:2], 2'b00};
        region   = REG_NONE;
        if ((wordAddr - RAM_BASE) < ramBytes) begin
            region = REG_RAM;
        end else if (wordAddr == KBD_DATA_ADDR) begin
            region = REG_KBD_DATA;
        end else if (wordAddr == KBD_STATUS_ADDR) begin
            region = REG_KBD_STATUS;
        end else if (wordAddr == LED_ADDR) begin
            region = REG_LED;
        end else if (wordAddr == CYCLE_ADDR) begin
            region = REG_CYCLE;
        end
        return region;
    endfunction

endpackage

// File: rtl/mem_io_responder_kbd_fifo.sv
// Keyboard scan-code FIFO (module kbd_fifo). Power-of-two depth so the
// pointers wrap naturally; sticky overflow flag records dropped codes.
module kbd_fifo
    import mem_io_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  push_i,
    input  logic [KBD_CODE_W-1:0] code_i,
    input  logic                  pop_i,
    input  logic                  clearOvf_i,
    output logic [KBD_CODE_W-1:0] headCode_o,
    output logic [CW-1:0]         count_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  overflow_o
);

    logic [KBD_CODE_W-1:0] store_q [DEPTH];
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  doPush, doPop;

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CW'(DEPTH));
    assign count_o    = count_q;
    assign overflow_o = ovf_q;
    assign headCode_o = store_q[head_q];

    // Next-state: a pop on a full FIFO frees the slot for a same-cycle push;
    // a refused push sets overflow, which wins over a same-cycle clear
    always_comb begin
        doPop   = pop_i && !empty_o;
        doPush  = push_i && (!full_o || doPop);
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (doPop) begin
            head_d = head_q + 1'b1;
        end
        if (doPush) begin
            tail_d = tail_q + 1'b1;
        end
        if (doPush && !doPop) begin
            count_d = count_q + 1'b1;
        end else if (doPop && !doPush) begin
            count_d = count_q - 1'b1;
        end
        if (clearOvf_i) begin
            ovf_d = 1'b0;
        end
        if (push_i && !doPush) begin
            ovf_d = 1'b1;
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Code storage is not reset; reset only blocks the write
    always_ff @(posedge clk_i) begin
        if (!reset_i && doPush) begin
            store_q[tail_q] <= code_i;
        end
    end

endmodule

// File: rtl/mem_io_responder.sv
// Memory and I/O responder for a single-cycle CPU: zero-latency data RAM,
// keyboard FIFO registers, LED register and an optional cycle counter.
// Optional feature macro: CYCLE_COUNTER_EN (enables the CYCLE register).
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int DMEM_WORDS = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memaddr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    input  logic        memread,
    output logic [31:0] readmem,
    input  logic [7:0]  kbd_code,
    input  logic        kbd_valid,
    output logic [15:0] led
);

    localparam int          AW        = $clog2(DMEM_WORDS);
    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] RAM_BYTES = 32'(DMEM_WORDS * 4);

    region_e               region;
    logic [31:0]           ramOffset;
    logic [AW-1:0]         ramIndex;
    logic [31:0]           ram_q [DMEM_WORDS];
    logic [15:0]           led_q, led_d;
    logic [KBD_CODE_W-1:0] headCode;
    logic [CW-1:0]         fifoCount;
    logic                  fifoEmpty;
    logic                  fifoFull;
    logic                  fifoOvf;
    logic                  kbdPop;
    logic                  kbdClearOvf;

    assign region      = decodeRegion(memaddr, RAM_BYTES);
    assign ramOffset   = memaddr - RAM_BASE;
    assign ramIndex    = ramOffset[AW+1:2];
    assign kbdPop      = memread && (region == REG_KBD_DATA);
    assign kbdClearOvf = memread && (region == REG_KBD_STATUS);
    assign led         = led_q;

    kbd_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_kbd_fifo (
        .clk_i     (clk),
        .reset_i   (reset),
        .push_i    (kbd_valid),
        .code_i    (kbd_code),
        .pop_i     (kbdPop),
        .clearOvf_i(kbdClearOvf),
        .headCode_o(headCode),
        .count_o   (fifoCount),
        .empty_o   (fifoEmpty),
        .full_o    (fifoFull),
        .overflow_o(fifoOvf)
    );

`ifdef CYCLE_COUNTER_EN
    logic [31:0] cycle_q, cycle_d;

    // Free-running counter; a write to its address restarts it from zero
    always_comb begin
        cycle_d = cycle_q + 32'd1;
        if (memwrite && (region == REG_CYCLE)) begin
            cycle_d = '0;
        end
    end

    // Cycle counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end
`endif

    // RAM writes land at the clock edge; contents survive reset
    always_ff @(posedge clk) begin
        if (!reset && memwrite && (region == REG_RAM)) begin
            ram_q[ramIndex] <= writedata;
        end
    end

    // LED next-state: only the low half of the store data is kept
    always_comb begin
        led_d = led_q;
        if (memwrite && (region == REG_LED)) begin
            led_d = writedata[15:0];
        end
    end

    // LED register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    // Load data mux, purely combinational so loads complete in one cycle
    always_comb begin
        readmem = '0;
        case (region)
            REG_RAM: begin
                readmem = ram_q[ramIndex];
            end
            REG_KBD_DATA: begin
                if (!fifoEmpty) begin
                    readmem[KBD_DATA_VALID_BIT]  = 1'b1;
                    readmem[KBD_CODE_W-1:0]      = headCode;
                end
            end
            REG_KBD_STATUS: begin
                readmem[KBD_STATUS_OVF_BIT] = fifoOvf;
                readmem[KBD_STATUS_CNT_LSB +: KBD_STATUS_CNT_W] =
                    KBD_STATUS_CNT_W'(fifoCount);
            end
            REG_LED: begin
                readmem[15:0] = led_q;
            end
            REG_CYCLE: begin
`ifdef CYCLE_COUNTER_EN
                readmem = cycle_q;
`else
                readmem = '0;
`endif
            end
            default: begin
                readmem = '0;
            end
        endcase
    end

    logic unused_status;
    assign unused_status = fifoFull ^ ramOffset[0] ^ ramOffset[1];

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder (default parameters).
// Expectations for the CYCLE register follow CYCLE_COUNTER_EN.
module tb_mem_io_responder;

    localparam logic [31:0] A_RAM10   = 32'h1001_0010;
    localparam logic [31:0] A_RAM0    = 32'h1001_0000;
    localparam logic [31:0] A_RAMEND  = 32'h1001_0400;
    localparam logic [31:0] A_UNMAP   = 32'h1003_0000;
    localparam logic [31:0] A_KDATA   = 32'h1002_0000;
    localparam logic [31:0] A_KSTAT   = 32'h1002_0004;
    localparam logic [31:0] A_LED     = 32'h1002_0008;
    localparam logic [31:0] A_CYCLE   = 32'h1002_000C;

    logic        clk;
    logic        reset;
    logic [31:0] memaddr;
    logic [31:0] writedata;
    logic        memwrite;
    logic        memread;
    logic [31:0] readmem;
    logic [7:0]  kbd_code;
    logic        kbd_valid;
    logic [15:0] led;

    int testCount;
    int failCount;

    mem_io_responder #(
        .DMEM_WORDS(256),
        .FIFO_DEPTH(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .memaddr  (memaddr),
        .writedata(writedata),
        .memwrite (memwrite),
        .memread  (memread),
        .readmem  (readmem),
        .kbd_code (kbd_code),
        .kbd_valid(kbd_valid),
        .led      (led)
    );

    // 10-time-unit clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive all CPU and keyboard inputs; called just after a falling edge
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wd,
                                 input logic we, input logic re,
                                 input logic kv, input logic [7:0] kc);
        memaddr   = addr;
        writedata = wd;
        memwrite  = we;
        memread   = re;
        kbd_valid = kv;
        kbd_code  = kc;
        #1;
    endtask

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one full cycle, ending just after the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] expCycle;
        testCount = 0;
        failCount = 0;
        reset     = 1'b1;
        applyStimulus(A_UNMAP, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        applyStimulus(A_KSTAT, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("reset_status", readmem, 32'h0000_0000);
        checkOutput("reset_led", {16'h0, led}, 32'h0000_0000);
        applyStimulus(A_KDATA, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("reset_kdata", readmem, 32'h0000_0000);

        // RAM write with old data visible in the same cycle
        applyStimulus(A_RAM10, 32'h1111_1111, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(A_RAM10, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("ram_old_same_cycle", readmem, 32'h1111_1111);
        tick();
        applyStimulus(A_RAM10, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("ram_new", readmem, 32'hDEAD_BEEF);
        applyStimulus(32'h1001_0011, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("ram_byte_offset", readmem, 32'hDEAD_BEEF);

        // Out-of-range and unmapped accesses must not alias into RAM
        applyStimulus(A_RAM0, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(A_RAMEND, 32'h5555_5555, 1'b1, 1'b0, 1'b0, 8'h00);
        checkOutput("ram_end_read", readmem, 32'h0000_0000);
        tick();
        applyStimulus(A_RAM0, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("ram_word0_kept", readmem, 32'hCAFE_F00D);
        applyStimulus(A_UNMAP, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("unmapped_read", readmem, 32'h0000_0000);

        // Two pushes then pops
        applyStimulus(A_UNMAP, 32'h0, 1'b0, 1'b0, 1'b1, 8'h1C);
        tick();
        applyStimulus(A_UNMAP, 32'h0, 1'b0, 1'b0, 1'b1, 8'h32);
        tick();
        applyStimulus(A_KSTAT, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("status_two", readmem, 32'h0000_0002);
        applyStimulus(A_KDATA, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("pop_first", readmem, 32'h0000_011C);
        tick();
        checkOutput("pop_second", readmem, 32'h0000_0132);
        tick();
        checkOutput("pop_empty", readmem, 32'h0000_0000);
        tick();
        applyStimulus(A_KSTAT, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("status_empty", readmem, 32'h0000_0000);

        // Nine pushes into an 8-deep FIFO: last one dropped, overflow set
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(A_UNMAP, 32'h0, 1'b0, 1'b0, 1'b1, 8'(i));
            tick();
        end
        applyStimulus(A_KSTAT, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("status_overflow", readmem, 32'h0000_0108);
        tick();
        applyStimulus(A_KSTAT, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("status_ovf_cleared", readmem, 32'h0000_0008);

        // Full FIFO: push while popping is accepted without overflow
        applyStimulus(A_KDATA, 32'h0, 1'b0, 1'b1, 1'b1, 8'hAA);
        checkOutput("full_pushpop_head", readmem, 32'h0000_0101);
        tick();
        applyStimulus(A_KSTAT, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("full_pushpop_status", readmem, 32'h0000_0008);
        for (int i = 2; i <= 8; i++) begin
            applyStimulus(A_KDATA, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00);
            checkOutput($sformatf("drain_%0d", i), readmem, 32'h0000_0100 | 32'(i));
            tick();
        end
        applyStimulus(A_KDATA, 32'h0, 1'b0, 1'b1, 1'b0, 8'h00);
        checkOutput("drain_aa_last", readmem, 32'h0000_01AA);
        tick();
        checkOutput("drain_done", readmem, 32'h0000_0000);

        // Writes to keyboard registers are ignored
        applyStimulus(A_KSTAT, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(A_KSTAT, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("kstat_write_ignored", readmem, 32'h0000_0000);

        // LED register
        applyStimulus(A_LED, 32'h1234_ABCD, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(A_LED, 32'h0, 1'b0, 1'b0, 1'b1, 8'h77);
        checkOutput("led_port", {16'h0, led}, 32'h0000_ABCD);
        checkOutput("led_read", readmem, 32'h0000_ABCD);
        tick();

        // Reset mid-run, with a competing LED write and push
        reset = 1'b1;
        applyStimulus(A_LED, 32'h0000_FFFF, 1'b1, 1'b0, 1'b1, 8'h55);
        tick();
        reset = 1'b0;
        applyStimulus(A_KSTAT, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("rst2_status", readmem, 32'h0000_0000);
        checkOutput("rst2_led", {16'h0, led}, 32'h0000_0000);
        applyStimulus(A_RAM10, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("rst2_ram_kept", readmem, 32'hDEAD_BEEF);

        // Cycle counter: 100 cycles after reset, then cleared by a write
        applyStimulus(A_CYCLE, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (100) tick();
`ifdef CYCLE_COUNTER_EN
        expCycle = 32'd100;
`else
        expCycle = 32'd0;
`endif
        checkOutput("cycle_100", readmem, expCycle);
        applyStimulus(A_CYCLE, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 8'h00);
        tick();
        applyStimulus(A_CYCLE, 32'h0, 1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("cycle_cleared", readmem, 32'h0000_0000);
        repeat (5) tick();
`ifdef CYCLE_COUNTER_EN
        expCycle = 32'd5;
`else
        expCycle = 32'd0;
`endif
        checkOutput("cycle_resumed", readmem, expCycle);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
